// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan decoder.
// Segment patterns are active-low, bit order seg[6]=a .. seg[0]=g, identical to the
// hex-to-7-segment encoder so both sides of the loopback use one table.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Scan-window qualification states.
  typedef enum logic [1:0] {
    StWait   = 2'd0,
    StSettle = 2'd1,
    StHeld   = 2'd2
  } seg_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern decoder.
// Ports:
//   seg   - active-low segment pattern, seg[6]=a .. seg[0]=g
//   value - decoded hex nibble (0 when blank or err)
//   blank - pattern is all segments off
//   err   - pattern is not a hex digit and not blank
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       blank,
  output logic       err
);

  always_comb begin
    value = 4'h0;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      SEG_0:     value = 4'h0;
      SEG_1:     value = 4'h1;
      SEG_2:     value = 4'h2;
      SEG_3:     value = 4'h3;
      SEG_4:     value = 4'h4;
      SEG_5:     value = 4'h5;
      SEG_6:     value = 4'h6;
      SEG_7:     value = 4'h7;
      SEG_8:     value = 4'h8;
      SEG_9:     value = 4'h9;
      SEG_A:     value = 4'hA;
      SEG_B:     value = 4'hB;
      SEG_C:     value = 4'hC;
      SEG_D:     value = 4'hD;
      SEG_E:     value = 4'hE;
      SEG_F:     value = 4'hF;
      SEG_BLANK: blank = 1'b1;
      default:   err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment bus reader: synchronizes seg/an, qualifies each strobe window for
// stability, decodes the pattern and keeps a per-digit register file.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   seg, an     - active-low segment lines and digit strobes (asynchronous to clk)
//   val         - decoded nibble per digit, digit i in val[4i+3:4i]
//   vld         - digit captured at least once since reset
//   blank, err  - last capture of the digit was all-off / unrecognized
//   upd         - pulse: a capture changed some val/blank/err
//   frame_done  - pulse: every digit captured since the previous pulse
//   err_cnt     - saturating count of unrecognized captures
// Build option: define SEG_SCAN_ERRCNT_EN to include the error counter; otherwise err_cnt is 0.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   an,
  output logic [4*NDIG-1:0] val,
  output logic [NDIG-1:0]   vld,
  output logic [NDIG-1:0]   blank,
  output logic [NDIG-1:0]   err,
  output logic              upd,
  output logic              frame_done,
  output logic [7:0]        err_cnt
);

  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Two-flop synchronizers plus a one-cycle history copy for change detection.
  logic [6:0]      seg_m_q, seg_s_q, seg_p_q;
  logic [NDIG-1:0] an_m_q, an_s_q, an_p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m_q <= '1;
      seg_s_q <= '1;
      seg_p_q <= '1;
      an_m_q  <= '1;
      an_s_q  <= '1;
      an_p_q  <= '1;
    end else begin
      seg_m_q <= seg;
      seg_s_q <= seg_m_q;
      seg_p_q <= seg_s_q;
      an_m_q  <= an;
      an_s_q  <= an_m_q;
      an_p_q  <= an_s_q;
    end
  end

  logic            changed;
  logic [NDIG-1:0] an_low;
  logic            one_hot;
  logic [IdxW-1:0] idx;

  assign changed = (seg_s_q != seg_p_q) || (an_s_q != an_p_q);
  assign an_low  = ~an_s_q;
  assign one_hot = (an_low != '0) && ((an_low & (an_low - NDIG'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (an_low[i]) idx = IdxW'(i);
    end
  end

  // Stability counter.
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    if (changed) begin
      cnt_d = 8'd0;
    end else if (cnt_q == 8'(STABLE_CYC)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // FSM.
  seg_state_e state_q, state_d;
  logic       cap_d;

  always_comb begin
    state_d = state_q;
    cap_d   = 1'b0;
    case (state_q)
      StWait: begin
        if (one_hot) state_d = StSettle;
      end
      StSettle: begin
        if (!one_hot) begin
          state_d = StWait;
        end else if (!changed && (cnt_q == 8'(STABLE_CYC - 1))) begin
          cap_d   = 1'b1;
          state_d = StHeld;
        end
      end
      StHeld: begin
        if (changed) state_d = one_hot ? StSettle : StWait;
      end
      default: state_d = StWait;
    endcase
  end

  // Decode the synchronized pattern; registered alongside the capture strobe.
  logic [3:0] dec_val;
  logic       dec_blank, dec_err;

  seg_pattern_decode u_decode (
    .seg   (seg_s_q),
    .value (dec_val),
    .blank (dec_blank),
    .err   (dec_err)
  );

  logic            cap_q;
  logic [IdxW-1:0] cap_idx_q;
  logic [3:0]      cap_val_q;
  logic            cap_blank_q, cap_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWait;
      cnt_q       <= 8'd0;
      cap_q       <= 1'b0;
      cap_idx_q   <= '0;
      cap_val_q   <= 4'h0;
      cap_blank_q <= 1'b0;
      cap_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      cap_idx_q   <= idx;
      cap_val_q   <= dec_val;
      cap_blank_q <= dec_blank;
      cap_err_q   <= dec_err;
    end
  end

  // Per-digit register file and frame tracking.
  logic [NDIG-1:0][3:0] val_q, val_d;
  logic [NDIG-1:0]      vld_q, vld_d, blank_q, blank_d, err_q, err_d;
  logic [NDIG-1:0]      mask_q, mask_d, mask_nxt;
  logic                 upd_q, upd_d, frame_q, frame_d;

  always_comb begin
    val_d    = val_q;
    vld_d    = vld_q;
    blank_d  = blank_q;
    err_d    = err_q;
    mask_d   = mask_q;
    mask_nxt = mask_q;
    upd_d    = 1'b0;
    frame_d  = 1'b0;
    if (cap_q) begin
      upd_d = (val_q[cap_idx_q] != cap_val_q) || (blank_q[cap_idx_q] != cap_blank_q) ||
              (err_q[cap_idx_q] != cap_err_q);
      val_d[cap_idx_q]   = cap_val_q;
      blank_d[cap_idx_q] = cap_blank_q;
      err_d[cap_idx_q]   = cap_err_q;
      vld_d[cap_idx_q]   = 1'b1;
      mask_nxt[cap_idx_q] = 1'b1;
      if (&mask_nxt) begin
        frame_d = 1'b1;
        mask_d  = '0;
      end else begin
        mask_d = mask_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q   <= '0;
      vld_q   <= '0;
      blank_q <= '0;
      err_q   <= '0;
      mask_q  <= '0;
      upd_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      val_q   <= val_d;
      vld_q   <= vld_d;
      blank_q <= blank_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      upd_q   <= upd_d;
      frame_q <= frame_d;
    end
  end

  assign val        = val_q;
  assign vld        = vld_q;
  assign blank      = blank_q;
  assign err        = err_q;
  assign upd        = upd_q;
  assign frame_done = frame_q;

`ifdef SEG_SCAN_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (cap_q && cap_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: each expected upd/frame_done event is queued with
// its cycle and register-file snapshot; a monitor pops and compares on every DUT event.
module tb_seg_scan_decoder;

  localparam int unsigned NDIG = 4;
  localparam int unsigned S    = 4;
`ifdef SEG_SCAN_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  // Hand-written pattern table for 0..F.
  localparam logic [6:0] PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000,
    7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010,
    7'b0110000, 7'b0111000
  };

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [6:0]        seg = 7'h7F;
  logic [NDIG-1:0]   an = '1;
  logic [4*NDIG-1:0] val;
  logic [NDIG-1:0]   vld, blank, err;
  logic              upd, frame_done;
  logic [7:0]        err_cnt;

  seg_scan_decoder #(
    .NDIG       (NDIG),
    .STABLE_CYC (S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .an         (an),
    .val        (val),
    .vld        (vld),
    .blank      (blank),
    .err        (err),
    .upd        (upd),
    .frame_done (frame_done),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic              upd;
    logic              fd;
    logic [4*NDIG-1:0] val;
    logic [NDIG-1:0]   vld;
    logic [NDIG-1:0]   blank;
    logic [NDIG-1:0]   err;
    logic [7:0]        ec;
  } ev_t;

  ev_t q[$];

  int checks = 0;
  int errors = 0;

  // Bench-side model of the register file.
  logic [4*NDIG-1:0] m_val   = '0;
  logic [NDIG-1:0]   m_vld   = '0;
  logic [NDIG-1:0]   m_blank = '0;
  logic [NDIG-1:0]   m_err   = '0;
  logic [NDIG-1:0]   m_mask  = '0;
  logic [7:0]        m_ec    = '0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (upd || frame_done)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: upd=%b frame_done=%b at cycle %0d, expected none",
                 upd, frame_done, cyc);
      end else begin
        e = q.pop_front();
        chk("ev_cycle", 64'(cyc), 64'(e.cyc));
        chk("ev_upd", 64'(upd), 64'(e.upd));
        chk("ev_frame_done", 64'(frame_done), 64'(e.fd));
        chk("ev_val", 64'(val), 64'(e.val));
        chk("ev_vld", 64'(vld), 64'(e.vld));
        chk("ev_blank", 64'(blank), 64'(e.blank));
        chk("ev_err", 64'(err), 64'(e.err));
        chk("ev_err_cnt", 64'(err_cnt), 64'(e.ec));
      end
    end
  end

  // Drive one window for len cycles. cap/dig/nib/kind are the hand-computed expectation:
  // kind 0 = hex value nib, 1 = blank, 2 = err.
  task automatic apply(input logic [NDIG-1:0] a, input logic [6:0] s, input int len,
                       input bit cap, input int dig, input logic [3:0] nib, input int kind);
    ev_t        e;
    logic [3:0] nv;
    bit         nb, ne, u, f;
    @(negedge clk);
    an  = a;
    seg = s;
    if (cap) begin
      nv = (kind == 0) ? nib : 4'h0;
      nb = (kind == 1);
      ne = (kind == 2);
      u  = (m_val[dig*4 +: 4] != nv) || (m_blank[dig] != nb) || (m_err[dig] != ne);
      m_val[dig*4 +: 4] = nv;
      m_blank[dig] = nb;
      m_err[dig]   = ne;
      m_vld[dig]   = 1'b1;
      m_mask[dig]  = 1'b1;
      f = &m_mask;
      if (f) m_mask = '0;
      if (ne && ERRCNT_EN && m_ec != 8'hFF) m_ec = m_ec + 8'd1;
      if (u || f) begin
        e.cyc = cyc + int'(S) + 4;
        e.upd = u;
        e.fd = f;
        e.val = m_val;
        e.vld = m_vld;
        e.blank = m_blank;
        e.err = m_err;
        e.ec = m_ec;
        q.push_back(e);
      end
    end
    repeat (len - 1) @(negedge clk);
  endtask

  task automatic idle(input int len);
    apply('1, 7'h7F, len, 1'b0, 0, 4'h0, 0);
  endtask

  task automatic drain_check(input string name);
    idle(12);
    chk(name, 64'(q.size()), 64'd0);
    chk({name, "_vld"}, 64'(vld), 64'(m_vld));
    chk({name, "_val"}, 64'(val), 64'(m_val));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // Reset state.
    chk("rst_val", 64'(val), 64'd0);
    chk("rst_vld", 64'(vld), 64'd0);
    chk("rst_blank", 64'(blank), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_upd", 64'(upd), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;
    idle(4);

    // Digit 0 shows 3 for 10 cycles.
    apply(4'b1110, 7'b0000110, 10, 1'b1, 0, 4'h3, 0);
    drain_check("t1_pending");

    // All 16 values on digit 2, then blank, then an unrecognized pattern.
    for (int i = 0; i < 16; i++) apply(4'b1011, PAT[i], 6, 1'b1, 2, 4'(i), 0);
    apply(4'b1011, 7'b1111111, 6, 1'b1, 2, 4'h0, 1);
    apply(4'b1011, 7'b1010101, 6, 1'b1, 2, 4'h0, 2);
    drain_check("t2_pending");
    chk("t2_blank", 64'(blank), 64'(m_blank));
    chk("t2_err", 64'(err), 64'(m_err));

    // Short glitch window on digit 1.
    apply(4'b1101, PAT[7], 3, 1'b0, 1, 4'h0, 0);
    drain_check("glitch_pending");

    // Two strobes low.
    apply(4'b1100, PAT[8], 20, 1'b0, 0, 4'h0, 0);
    drain_check("twolow_pending");

    // Reset in the middle of a settling window.
    apply(4'b1101, PAT[5], 4, 1'b0, 1, 4'h0, 0);
    rst_n = 1'b0;
    an    = '1;
    seg   = 7'h7F;
    #1;
    chk("midrst_val", 64'(val), 64'd0);
    chk("midrst_vld", 64'(vld), 64'd0);
    chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
    m_val = '0; m_vld = '0; m_blank = '0; m_err = '0; m_mask = '0; m_ec = '0;
    @(negedge clk);
    chk("midrst_blank", 64'(blank), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    drain_check("midrst_pending");

    // "1234" across digits 3..0, two frames.
    for (int r = 0; r < 2; r++) begin
      apply(4'b0111, PAT[1], 6, 1'b1, 3, 4'h1, 0);
      apply(4'b1011, PAT[2], 6, 1'b1, 2, 4'h2, 0);
      apply(4'b1101, PAT[3], 6, 1'b1, 1, 4'h3, 0);
      apply(4'b1110, PAT[4], 6, 1'b1, 0, 4'h4, 0);
    end
    drain_check("frame_pending");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
